// File: rtl/net_pkg.sv
// Shared select codes, arbiter state type and index-to-select mapping for the
// three-port channel arbiter.
package net_pkg;

  localparam logic [1:0] SEL_P0   = 2'b10;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_P2   = 2'b00;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_e;

  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    logic [1:0] sel;
    unique case (idx)
      2'd0:    sel = SEL_P0;
      2'd1:    sel = SEL_P1;
      2'd2:    sel = SEL_P2;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search over three requesters, starting just after
// the last owner and wrapping back to it.
module rr_pick (
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic       found_o,
  output logic [1:0] idx_o
);

  logic [1:0] ord [3];

  always_comb begin
    unique case (last_i)
      2'd0:    ord = '{2'd1, 2'd2, 2'd0};
      2'd1:    ord = '{2'd2, 2'd0, 2'd1};
      default: ord = '{2'd0, 2'd1, 2'd2};
    endcase
  end

  always_comb begin
    found_o = 1'b0;
    idx_o   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!found_o && req_i[ord[k]]) begin
        found_o = 1'b1;
        idx_o   = ord[k];
      end
    end
  end

endmodule

// File: rtl/net_arbiter.sv
// Round-robin arbiter for one shared channel: grants only requesting ports,
// holds while the owner requests, and bounds tenure to MAX_HOLD under contention.
module net_arbiter
  import net_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] s,
  output logic       busy
);

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  arb_state_e state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d;
  logic       busy_q, busy_d;
  logic [1:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;

  logic [2:0] owner_mask;
  logic [2:0] pick_mask;
  logic       found;
  logic [1:0] win;
  logic       grant_new;

  // While owning, last_q is the owner; exclude it so handoffs go to someone else.
  assign owner_mask = (state_q == OWN) ? (3'b001 << last_q) : 3'b000;
  assign pick_mask  = req & ~owner_mask;

  rr_pick u_rr_pick (
    .req_i   (pick_mask),
    .last_i  (last_q),
    .found_o (found),
    .idx_o   (win)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    grant_new = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) grant_new = 1'b1;
      end
      OWN: begin
        if (!req[last_q] || (hold_q == MaxHold && found)) begin
          if (found) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            hold_d  = 4'd0;
          end
        end else if (hold_q != MaxHold) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_new) begin
      state_d = OWN;
      last_d  = win;
      hold_d  = 4'd1;
    end

    gnt_d  = (state_d == OWN) ? (3'b001 << last_d) : 3'b000;
    s_d    = (state_d == OWN) ? idx_to_sel(last_d) : SEL_NONE;
    busy_d = (state_d == OWN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      s_q     <= SEL_NONE;
      busy_q  <= 1'b0;
      last_q  <= 2'd2;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt  = gnt_q;
  assign s    = s_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_net_arbiter.sv
// Bench for net_arbiter: two instances (MAX_HOLD 1 and 4) share stimulus and are
// checked every cycle against an integer ownership model plus directed literals.
module tb_net_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = 3'b000;

  logic [2:0] gnt_a  [2];
  logic [1:0] s_a    [2];
  logic       busy_a [2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  net_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt_a[0]),
    .s     (s_a[0]),
    .busy  (busy_a[0])
  );

  net_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt_a[1]),
    .s     (s_a[1]),
    .busy  (busy_a[1])
  );

  // Model: owner index (-1 = none), last owner, cycles held so far.
  int         maxh    [2] = '{1, 4};
  int         m_owner [2] = '{-1, -1};
  int         m_last  [2] = '{2, 2};
  int         m_ten   [2] = '{0, 0};
  logic [2:0] req_prev = 3'b000;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_owner[i] = -1;
        m_last[i]  = 2;
        m_ten[i]   = 0;
      end else if (m_owner[i] < 0) begin
        for (int k = 1; k <= 3; k++) begin
          int p;
          p = (m_last[i] + k) % 3;
          if (m_owner[i] < 0 && req[p]) begin
            m_owner[i] = p;
            m_last[i]  = p;
            m_ten[i]   = 1;
          end
        end
      end else begin
        int others;
        others = 0;
        for (int p = 0; p < 3; p++) if (p != m_owner[i] && req[p]) others++;
        if (!req[m_owner[i]] || (m_ten[i] >= maxh[i] && others > 0)) begin
          int nxt;
          nxt = -1;
          for (int k = 1; k <= 2; k++) begin
            int p;
            p = (m_last[i] + k) % 3;
            if (nxt < 0 && req[p]) nxt = p;
          end
          m_owner[i] = nxt;
          if (nxt >= 0) begin
            m_last[i] = nxt;
            m_ten[i]  = 1;
          end else begin
            m_ten[i] = 0;
          end
        end else if (m_ten[i] < maxh[i]) begin
          m_ten[i] = m_ten[i] + 1;
        end
      end
    end
    req_prev = reset ? 3'b000 : req;
  end

  function automatic logic [1:0] exp_sel(input int owner);
    case (owner)
      0:       return 2'b10;
      1:       return 2'b01;
      2:       return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model compare and invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [2:0] eg;
        eg = (m_owner[i] < 0) ? 3'b000 : (3'b001 << m_owner[i]);
        chk($sformatf("model_gnt[%0d]", i), {1'b0, gnt_a[i]}, {1'b0, eg});
        chk($sformatf("model_s[%0d]", i), {2'b00, s_a[i]}, {2'b00, exp_sel(m_owner[i])});
        chk($sformatf("model_busy[%0d]", i), {3'b000, busy_a[i]}, {3'b000, (m_owner[i] >= 0)});
        chk($sformatf("inv_onehot[%0d]", i), {3'b000, $onehot0(gnt_a[i])}, 4'd1);
        chk($sformatf("inv_req[%0d]", i), {1'b0, gnt_a[i] & ~req_prev}, 4'd0);
      end
    end
  end

  task automatic tick(input logic [2:0] r, input logic rst);
    req   = r;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset priority, MAX_HOLD=1 rotation
    tick(3'b000, 1'b1);
    tick(3'b000, 1'b1);
    chk_en = 1'b1;
    chk("rst_gnt", {1'b0, gnt_a[0]}, 4'b0000);
    chk("rst_s", {2'b00, s_a[0]}, 4'b0011);
    chk("rst_busy", {3'b000, busy_a[0]}, 4'd0);
    tick(3'b111, 1'b0);
    chk("rot_g0", {1'b0, gnt_a[0]}, 4'b0001);
    chk("rot_s0", {2'b00, s_a[0]}, 4'b0010);
    tick(3'b111, 1'b0);
    chk("rot_g1", {1'b0, gnt_a[0]}, 4'b0010);
    chk("rot_s1", {2'b00, s_a[0]}, 4'b0001);
    tick(3'b111, 1'b0);
    chk("rot_g2", {1'b0, gnt_a[0]}, 4'b0100);
    chk("rot_s2", {2'b00, s_a[0]}, 4'b0000);
    tick(3'b111, 1'b0);
    chk("rot_g3", {1'b0, gnt_a[0]}, 4'b0001);
    chk("rot_s3", {2'b00, s_a[0]}, 4'b0010);
    chk("rot_busy", {3'b000, busy_a[0]}, 4'd1);

    // 2: hold limit with MAX_HOLD=4
    tick(3'b000, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(3'b001, 1'b0);
      chk("hold_p0", {1'b0, gnt_a[1]}, 4'b0001);
    end
    tick(3'b011, 1'b0);
    chk("hold_4th", {1'b0, gnt_a[1]}, 4'b0001);
    tick(3'b011, 1'b0);
    chk("hold_preempt", {1'b0, gnt_a[1]}, 4'b0010);
    tick(3'b000, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick(3'b001, 1'b0);
      chk("alone_hold", {1'b0, gnt_a[1]}, 4'b0001);
    end

    // 3: zero-bubble handoff 1 -> 2
    tick(3'b000, 1'b1);
    tick(3'b010, 1'b0);
    chk("zb_own1", {1'b0, gnt_a[1]}, 4'b0010);
    tick(3'b100, 1'b0);
    chk("zb_own2", {1'b0, gnt_a[1]}, 4'b0100);
    chk("zb_busy", {3'b000, busy_a[1]}, 4'd1);

    // 4: idle return, then pointer priority with last=1
    tick(3'b000, 1'b1);
    tick(3'b010, 1'b0);
    tick(3'b000, 1'b0);
    chk("idle_gnt", {1'b0, gnt_a[1]}, 4'b0000);
    chk("idle_s", {2'b00, s_a[1]}, 4'b0011);
    chk("idle_busy", {3'b000, busy_a[1]}, 4'd0);
    tick(3'b001, 1'b0);
    chk("idle_p0", {1'b0, gnt_a[1]}, 4'b0001);
    tick(3'b000, 1'b1);
    tick(3'b010, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b101, 1'b0);
    chk("prio_p2", {1'b0, gnt_a[1]}, 4'b0100);

    // 5: reset mid-tenure
    tick(3'b000, 1'b1);
    tick(3'b100, 1'b0);
    chk("mt_own2", {1'b0, gnt_a[1]}, 4'b0100);
    tick(3'b100, 1'b1);
    chk("mt_gnt", {1'b0, gnt_a[1]}, 4'b0000);
    chk("mt_s", {2'b00, s_a[1]}, 4'b0011);
    tick(3'b101, 1'b0);
    chk("mt_p0", {1'b0, gnt_a[1]}, 4'b0001);
    chk("mt_p0_d1", {1'b0, gnt_a[0]}, 4'b0001);

    tick(3'b000, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/net_arbiter.md
# net_arbiter

Round-robin arbiter that shares one interconnect output channel between three requesters. It drives the channel mux select with the same 2-bit code order the free-running cycler uses: port 0 = 2'b10, port 1 = 2'b01, port 2 = 2'b00. Unlike the cycler, it only grants ports that are requesting, holds a grant while the owner keeps requesting, and bounds tenure when others are waiting. It sits between the requester interfaces and the channel mux.

## Interface

**Parameters**
- MAX_HOLD, default 4: maximum consecutive grant cycles for one owner while another port is requesting; legal range 1..15.

**Ports**
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  3  request per port; bit i = port i; level-sensitive.
- gnt  output  3  one-hot grant, registered; all-zero when idle.
- s  output  2  channel mux select, registered:
  - 2'b10 = port 0
  - 2'b01 = port 1
  - 2'b00 = port 2
  - 2'b11 = no owner
- busy  output  1  registered; high whenever gnt is non-zero.

## Operation

**States**
- IDLE: no owner.
- OWN: one port holds the grant.

**Pointer**
- last, 2 bits: index of the most recent owner; reset value 2.
- Priority order for each pick is last+1, last+2, last (mod 3). After reset, port 0 has top priority.

**Hold counter**
- hold_cnt, 4 bits: cycles the current owner has held the grant.
- Set to 1 on each new grant. Increments while the owner keeps the grant. Saturates at MAX_HOLD.

**Transitions** (evaluated on every posedge)
- IDLE, req == 0: stay IDLE.
- IDLE, req != 0: grant the highest-priority requesting port, go to OWN, set last to the granted index.
- OWN, owner's req low:
  - Pick among the other ports.
  - If any is requesting, hand off directly, with no idle cycle.
  - Otherwise go to IDLE.
- OWN, owner's req high, hold_cnt == MAX_HOLD, another port requesting: preempt and hand off to the next port in round-robin order.
- OWN, owner's req high, otherwise: keep the grant.
  - The owner keeps the grant indefinitely when no other port requests.

**Output encoding**
- s and gnt always agree: gnt one-hot ↔ s holds that port's code; gnt 0 ↔ s = 2'b11.
- busy = |gnt.

**Reset**
- reset high at a posedge forces the following, overriding any in-progress grant:
  - state IDLE, gnt 3'b000, s 2'b11, busy 0
  - last 2, hold_cnt 0
- reset mid-tenure drops the grant the following cycle. No partial handoff occurs.

**Simultaneous events**
- The owner dropping req in the same cycle that another port asserts req gives a zero-bubble handoff.
- Multiple new requests in one cycle are resolved purely by pointer order.

## Timing

- Grant latency: req sampled at edge N produces gnt/s valid after edge N (one cycle). No combinational path from req to any output.
- Release latency: owner req low at edge N moves gnt to the next owner, or to 0, after edge N.
- Tenure under contention:
  - An owner granted at edge N, with continuous contention, loses the grant at edge N+MAX_HOLD.
  - It therefore holds exactly MAX_HOLD cycles.
- MAX_HOLD = 1 with all ports requesting: grant rotates every cycle.
  - Port order 0,1,2,0,…
  - s sequence 10,01,00,10,…, identical to the cycler.
- Requesters must treat gnt as the only ownership indication. Deasserting req is the release.

## Structure

**Package net_pkg**
- Select codes: SEL_P0 = 2'b10, SEL_P1 = 2'b01, SEL_P2 = 2'b00, SEL_NONE = 2'b11.
- Arbiter state enum: IDLE, OWN.
- Function idx_to_sel, mapping port index to select code.

**Sub-module rr_pick** (combinational)
- Inputs: 3-bit request mask and 2-bit last pointer.
- Outputs: found flag and 2-bit winner index.
- Instantiated once. The top masks out the current owner when searching for a handoff.

**Registers in top:** state, gnt, s, last, hold_cnt.

## Test plan

1. Reset priority: hold reset 2 cycles, then req = 3'b111 with MAX_HOLD = 1.
   - gnt sequence 001, 010, 100, 001.
   - s sequence 10, 01, 00, 10.
   - busy stays 1.
2. Hold limit: MAX_HOLD = 4; req = 3'b001 for 3 cycles, then 3'b011.
   - Port 0 holds gnt for 4 cycles total after its grant; port 1 is granted on the next cycle.
   - Port 0 alone: holds indefinitely (checked for 20 cycles).
3. Zero-bubble handoff: port 1 owner drops req in the same cycle that port 2 raises req.
   - gnt goes 010 → 100 on the next edge.
   - busy never drops.
4. Idle return: the sole owner drops req.
   - Next cycle: gnt 000, s 11, busy 0.
   - Port 0 then requesting, with last = 1: port 0 is granted the next cycle. Also check that port 2 is preferred if both port 0 and port 2 request.
5. Reset mid-tenure: assert reset while port 2 owns.
   - Next cycle: gnt 000, s 11.
   - After release with req = 3'b101, port 0 is granted first.
6. Invariant check every cycle:
   - gnt is one-hot or zero.
   - s matches idx_to_sel(gnt), or 11 when gnt is 0.
   - gnt is never given to a port whose req was low at the granting edge.
